// File: rtl/dtcore32_mem_arbiter.sv
// rtl/dtcore32_mem_arbiter.sv - shares one single-ported memory bus between fetch and data ports
// One transaction in flight; registered bus outputs, per-port ack/err, fetch starvation guard, bus timeout.
module dtcore32_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_IF_STARVE  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    imem_req_i,
  input  logic [ADDR_WIDTH-1:0]   imem_addr_i,
  output logic [DATA_WIDTH-1:0]   imem_rdata_o,
  output logic                    imem_ack_o,
  output logic                    imem_err_o,
  input  logic                    dmem_req_i,
  input  logic                    dmem_we_i,
  input  logic [DATA_WIDTH/8-1:0] dmem_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   dmem_addr_i,
  input  logic [DATA_WIDTH-1:0]   dmem_wdata_i,
  output logic [DATA_WIDTH-1:0]   dmem_rdata_o,
  output logic                    dmem_ack_o,
  output logic                    dmem_err_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  input  logic                    bus_ack_i
);

  localparam int STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int STARVE_WIDTH = $clog2(MAX_IF_STARVE + 1);
  localparam int TIMER_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [STARVE_WIDTH-1:0] STARVE_LIMIT = STARVE_WIDTH'(MAX_IF_STARVE);
  localparam logic [TIMER_WIDTH-1:0]  TIMER_LAST   = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                  state;
  logic [STARVE_WIDTH-1:0] starve_cnt;
  logic [TIMER_WIDTH-1:0]  timer_cnt;

  logic                  pick_data;
  logic                  bus_done;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] resp_data;

  // Data wins unless a waiting fetch has already been passed over MAX_IF_STARVE times.
  assign pick_data = dmem_req_i & (~imem_req_i | (starve_cnt < STARVE_LIMIT));

  // A bus cycle ends on ack or when the timer reaches its last count; ack wins a tie.
  assign bus_done  = bus_ack_i | (timer_cnt == TIMER_LAST);
  assign resp_err  = ~bus_ack_i;
  assign resp_data = bus_ack_i ? bus_rdata_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      timer_cnt    <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_wstrb_o  <= '0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      imem_rdata_o <= '0;
      imem_ack_o   <= 1'b0;
      imem_err_o   <= 1'b0;
      dmem_rdata_o <= '0;
      dmem_ack_o   <= 1'b0;
      dmem_err_o   <= 1'b0;
    end else begin
      imem_ack_o <= 1'b0;
      imem_err_o <= 1'b0;
      dmem_ack_o <= 1'b0;
      dmem_err_o <= 1'b0;

      case (state)
        IDLE: begin
          timer_cnt <= '0;
          if (pick_data) begin
            state       <= DBUS;
            bus_req_o   <= 1'b1;
            bus_we_o    <= dmem_we_i;
            bus_wstrb_o <= dmem_we_i ? dmem_wstrb_i : {STRB_WIDTH{1'b0}};
            bus_addr_o  <= dmem_addr_i;
            bus_wdata_o <= dmem_wdata_i;
            if (imem_req_i && (starve_cnt != STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (imem_req_i) begin
            state       <= IBUS;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_wstrb_o <= '0;
            bus_addr_o  <= imem_addr_i;
            bus_wdata_o <= '0;
            starve_cnt  <= '0;
          end
        end

        IBUS, DBUS: begin
          if (bus_done) begin
            state     <= RESP;
            bus_req_o <= 1'b0;
            if (state == DBUS) begin
              dmem_ack_o   <= 1'b1;
              dmem_err_o   <= resp_err;
              dmem_rdata_o <= resp_data;
            end else begin
              imem_ack_o   <= 1'b1;
              imem_err_o   <= resp_err;
              imem_rdata_o <= resp_data;
            end
          end else begin
            timer_cnt <= timer_cnt + 1'b1;
          end
        end

        // The requester sees its ack this cycle and drops its request, so no new decision here.
        RESP: begin
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtcore32_mem_arbiter.sv
// tb/tb_dtcore32_mem_arbiter.sv - directed vector bench for dtcore32_mem_arbiter
// Cycle vectors for basic fetch/data arbitration plus hand sequences for multi-cycle cases.
module tb_dtcore32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        imem_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        dmem_err;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int total = 0;
  int passed = 0;

  dtcore32_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_IF_STARVE(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_rdata_o(imem_rdata),
    .imem_ack_o(imem_ack), .imem_err_o(imem_err),
    .dmem_req_i(dmem_req), .dmem_we_i(dmem_we), .dmem_wstrb_i(dmem_wstrb),
    .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata), .dmem_rdata_o(dmem_rdata),
    .dmem_ack_o(dmem_ack), .dmem_err_o(dmem_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_wstrb_o(bus_wstrb),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dwstrb;
    logic [31:0] daddr;
    logic        back;
    logic [31:0] brdata;
    logic        e_breq;
    logic        e_bwe;
    logic [3:0]  e_bwstrb;
    logic [31:0] e_baddr;
    logic        e_iack;
    logic [31:0] e_irdata;
    logic        e_dack;
    logic [31:0] e_drdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_d[6];
    int seen;

    exp_d = '{1, 1, 0, 1, 1, 0};
    //           ireq  iaddr        dreq  dwe   wstrb  daddr        back  brdata         breq  bwe   bstrb  baddr        iack  irdata         dack  drdata
    vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'h0, 32'h100, 1'b0, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h100, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h100, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h400, 1'b1, 1'b0, 4'hF, 32'h200, 1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h100, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h400, 1'b1, 1'b0, 4'hF, 32'h200, 1'b1, 32'h11112222, 1'b1, 1'b0, 4'h0, 32'h200, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h200, 1'b0, 32'hDEADBEEF, 1'b1, 32'h11112222};
    vecs[7]  = '{1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h200, 1'b0, 32'hDEADBEEF, 1'b0, 32'h11112222};
    vecs[8]  = '{1'b1, 32'h400, 1'b0, 1'b0, 4'h0, 32'h0,   1'b1, 32'h33334444, 1'b1, 1'b0, 4'h0, 32'h400, 1'b0, 32'hDEADBEEF, 1'b0, 32'h11112222};
    vecs[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h400, 1'b1, 32'h33334444, 1'b0, 32'h11112222};
    vecs[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 32'h0,        1'b0, 1'b0, 4'h0, 32'h400, 1'b0, 32'h33334444, 1'b0, 32'h11112222};

    rst = 1'b1;
    imem_req = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_wstrb = '0; dmem_addr = '0; dmem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;

    // Reset state
    #12;
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_imem_ack", {31'b0, imem_ack}, 32'd0);
    chk("rst_dmem_ack", {31'b0, dmem_ack}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fetch alone, then simultaneous load+fetch (data first)
    for (int i = 0; i < 11; i++) begin
      tick();
      imem_req = vecs[i].ireq; imem_addr = vecs[i].iaddr;
      dmem_req = vecs[i].dreq; dmem_we = vecs[i].dwe; dmem_wstrb = vecs[i].dwstrb;
      dmem_addr = vecs[i].daddr; dmem_wdata = '0;
      bus_ack = vecs[i].back; bus_rdata = vecs[i].brdata;
      @(negedge clk);
      chk($sformatf("v%0d_bus_req", i), {31'b0, bus_req}, {31'b0, vecs[i].e_breq});
      chk($sformatf("v%0d_bus_we", i), {31'b0, bus_we}, {31'b0, vecs[i].e_bwe});
      chk($sformatf("v%0d_bus_wstrb", i), {28'b0, bus_wstrb}, {28'b0, vecs[i].e_bwstrb});
      chk($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].e_baddr);
      chk($sformatf("v%0d_imem_ack", i), {31'b0, imem_ack}, {31'b0, vecs[i].e_iack});
      chk($sformatf("v%0d_imem_rdata", i), imem_rdata, vecs[i].e_irdata);
      chk($sformatf("v%0d_dmem_ack", i), {31'b0, dmem_ack}, {31'b0, vecs[i].e_dack});
      chk($sformatf("v%0d_dmem_rdata", i), dmem_rdata, vecs[i].e_drdata);
      chk($sformatf("v%0d_errs", i), {30'b0, imem_err, dmem_err}, 32'd0);
    end

    // Starvation guard: grant order D,D,I,D,D,I with MAX_IF_STARVE=2
    bus_ack = 1'b0; bus_rdata = 32'h0;
    imem_req = 1'b1; imem_addr = 32'h800;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_wstrb = 4'h0; dmem_addr = 32'h900;
    for (int g = 0; g < 6; g++) begin
      seen = 0;
      for (int w = 0; w < 10 && seen == 0; w++) begin
        @(negedge clk);
        if (bus_req) seen = 1;
      end
      if (seen == 0) begin
        chk($sformatf("grant%0d_wait", g), 32'd0, 32'd1);
      end else begin
        chk($sformatf("grant%0d_is_data", g), (bus_addr == 32'h900) ? 32'd1 : 32'd0, exp_d[g]);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
      end
    end
    imem_req = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk("starve_last_imem_ack", {31'b0, imem_ack}, 32'd1);
    chk("starve_last_dmem_ack", {31'b0, dmem_ack}, 32'd0);

    // Store with 3 wait states
    tick();
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h300; dmem_wdata = 32'hA5A51234; dmem_wstrb = 4'b0011;
    bus_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) bus_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("st%0d_bus_req", k), {31'b0, bus_req}, 32'd1);
      chk($sformatf("st%0d_bus_addr", k), bus_addr, 32'h300);
      chk($sformatf("st%0d_bus_we", k), {31'b0, bus_we}, 32'd1);
      chk($sformatf("st%0d_bus_wstrb", k), {28'b0, bus_wstrb}, 32'h3);
      chk($sformatf("st%0d_bus_wdata", k), bus_wdata, 32'hA5A51234);
      chk($sformatf("st%0d_no_ack_yet", k), {31'b0, dmem_ack}, 32'd0);
    end
    tick();
    bus_ack = 1'b0; dmem_req = 1'b0; dmem_we = 1'b0; dmem_wstrb = 4'h0;
    @(negedge clk);
    chk("st_dmem_ack", {31'b0, dmem_ack}, 32'd1);
    chk("st_dmem_err", {31'b0, dmem_err}, 32'd0);
    chk("st_bus_req_drop", {31'b0, bus_req}, 32'd0);
    chk("st_imem_ack", {31'b0, imem_ack}, 32'd0);
    tick();
    @(negedge clk);
    chk("st_ack_one_cycle", {31'b0, dmem_ack}, 32'd0);

    // Timeout after 8 cycles, stray ack afterwards ignored
    bus_rdata = 32'hFFFF0000;
    tick();
    dmem_req = 1'b1; dmem_addr = 32'h500;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("to%0d_bus_req", k), {31'b0, bus_req}, 32'd1);
      chk($sformatf("to%0d_no_ack", k), {31'b0, dmem_ack}, 32'd0);
    end
    tick();
    dmem_req = 1'b0;
    @(negedge clk);
    chk("to_bus_req_drop", {31'b0, bus_req}, 32'd0);
    chk("to_dmem_ack", {31'b0, dmem_ack}, 32'd1);
    chk("to_dmem_err", {31'b0, dmem_err}, 32'd1);
    chk("to_dmem_rdata", dmem_rdata, 32'd0);
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    @(negedge clk);
    chk("stray_bus_req", {31'b0, bus_req}, 32'd0);
    chk("stray_acks", {30'b0, imem_ack, dmem_ack}, 32'd0);
    chk("stray_err", {31'b0, dmem_err}, 32'd0);
    chk("stray_rdata_hold", dmem_rdata, 32'd0);

    // Asynchronous reset mid-DBUS, then a clean fetch
    tick();
    dmem_req = 1'b1; dmem_addr = 32'h600;
    tick();
    @(negedge clk);
    chk("rstmid_bus_req_before", {31'b0, bus_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_bus_req_drop", {31'b0, bus_req}, 32'd0);
    chk("rstmid_no_ack", {31'b0, dmem_ack}, 32'd0);
    @(negedge clk);
    rst = 1'b0; dmem_req = 1'b0;
    tick();
    @(negedge clk);
    chk("rstpost_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rstpost_no_ack", {30'b0, imem_ack, dmem_ack}, 32'd0);
    tick();
    imem_req = 1'b1; imem_addr = 32'h700;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rstpost_fetch_bus_req", {31'b0, bus_req}, 32'd1);
    chk("rstpost_fetch_addr", bus_addr, 32'h700);
    tick();
    bus_ack = 1'b0; imem_req = 1'b0;
    @(negedge clk);
    chk("rstpost_imem_ack", {31'b0, imem_ack}, 32'd1);
    chk("rstpost_imem_rdata", imem_rdata, 32'hCAFEF00D);
    chk("rstpost_imem_err", {31'b0, imem_err}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
